// File: rtl/div_avalon_pkg.sv
// div_avalon_pkg: divider slave register map and master FSM state encoding
package div_avalon_pkg;
  localparam logic [2:0] SET_DIVIDEND  = 3'd0;
  localparam logic [2:0] SET_DIVISOR   = 3'd1;
  localparam logic [2:0] START         = 3'd2;
  localparam logic [2:0] GET_QUOTIENT  = 3'd3;
  localparam logic [2:0] GET_REMAINDER = 3'd4;
  localparam logic [2:0] GET_READY     = 3'd5;
  localparam logic [2:0] DONE_TRG      = 3'd6;
  typedef enum logic [3:0] {
    IDLE, PRE_CLR, WR_DVND, WR_DVSR, WR_START, WAIT_IRQ, RD_QUO, RD_RMD, CLR_DONE, RESP
  } state_t;
endpackage

// File: rtl/div_avalon_master.sv
// div_avalon_master: runs one divide job on the Avalon-MM divider slave per client request
module div_avalon_master
  import div_avalon_pkg::*;
#(
  parameter int W = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TW = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [W-1:0] job_dvnd,
  input  logic [W-1:0] job_dvsr,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_quo,
  output logic [W-1:0] res_rmd,
  output logic         res_err,
  output logic         busy,
  output logic [2:0]   avm_address,
  output logic         avm_chipselect,
  output logic         avm_write,
  output logic         avm_read,
  output logic [W-1:0] avm_writedata,
  input  logic [W-1:0] avm_readdata,
  input  logic         avm_waitrequest,
  input  logic         div_irq
);
  state_t state, state_nxt;
  logic [W-1:0] dvnd, dvsr;
  logic [TW-1:0] cnt;
  logic xfer, timeout;
  assign job_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign res_valid = state == RESP;
  assign xfer      = avm_chipselect & ~avm_waitrequest;
  assign timeout   = cnt == TW'(TIMEOUT_CYC - 1);
  // bus signals are a pure function of state, so they hold across waitrequest stalls
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_read       = 1'b0;
    avm_address    = 3'd0;
    avm_writedata  = '0;
    case (state)
      PRE_CLR:  begin avm_chipselect = 1'b1; avm_write = 1'b1; avm_address = DONE_TRG; avm_writedata = W'(1); end
      WR_DVND:  begin avm_chipselect = 1'b1; avm_write = 1'b1; avm_address = SET_DIVIDEND; avm_writedata = dvnd; end
      WR_DVSR:  begin avm_chipselect = 1'b1; avm_write = 1'b1; avm_address = SET_DIVISOR; avm_writedata = dvsr; end
      WR_START: begin avm_chipselect = 1'b1; avm_write = 1'b1; avm_address = START; end
      RD_QUO:   begin avm_chipselect = 1'b1; avm_read = 1'b1; avm_address = GET_QUOTIENT; end
      RD_RMD:   begin avm_chipselect = 1'b1; avm_read = 1'b1; avm_address = GET_REMAINDER; end
      CLR_DONE: begin avm_chipselect = 1'b1; avm_write = 1'b1; avm_address = DONE_TRG; avm_writedata = W'(1); end
      default:  ;
    endcase
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (job_valid) state_nxt = div_irq ? PRE_CLR : WR_DVND;
      PRE_CLR:  if (xfer) state_nxt = WR_DVND;
      WR_DVND:  if (xfer) state_nxt = WR_DVSR;
      WR_DVSR:  if (xfer) state_nxt = WR_START;
      WR_START: if (xfer) state_nxt = WAIT_IRQ;
      WAIT_IRQ: state_nxt = div_irq ? RD_QUO : timeout ? RESP : WAIT_IRQ;
      RD_QUO:   if (xfer) state_nxt = RD_RMD;
      RD_RMD:   if (xfer) state_nxt = CLR_DONE;
      CLR_DONE: if (xfer) state_nxt = RESP;
      RESP:     if (res_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      dvnd    <= '0;
      dvsr    <= '0;
      cnt     <= '0;
      res_quo <= '0;
      res_rmd <= '0;
      res_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= state != WAIT_IRQ ? '0 : cnt + TW'(cnt != '1);
      if (job_ready && job_valid) begin
        dvnd    <= job_dvnd;
        dvsr    <= job_dvsr;
        res_err <= 1'b0;
      end
      if (state == RD_QUO && xfer) res_quo <= avm_readdata;
      if (state == RD_RMD && xfer) res_rmd <= avm_readdata;
      if (state == WAIT_IRQ && !div_irq && timeout) begin
        res_err <= 1'b1;
        res_quo <= '0;
        res_rmd <= '0;
      end
    end
  end
endmodule
